// File: rtl/video_crop_measure_if.sv
// ----------------------------------------------------------------------------
// video_crop_measure_if
//   Pixel stream bundle between the video mixer and downstream consumers.
//   One instance carries the stream into video_crop_measure, another carries
//   the cropped stream out of it.
//
//   ce       pixel clock enable (CE_PIXEL / CE_OUT)
//   r, g, b  8-bit colour (VGA_R/G/B)
//   hs, vs   positive sync pulses (VGA_HS / VGA_VS)
//   de       active-area flag (VGA_DE)
//
//   master : drives the stream
//   slave  : receives the stream
// ----------------------------------------------------------------------------
interface video_crop_measure_if;
  logic       ce;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;
  logic       hs;
  logic       vs;
  logic       de;

  modport master (output ce, r, g, b, hs, vs, de);
  modport slave  (input  ce, r, g, b, hs, vs, de);
endinterface

// File: rtl/video_crop_measure.sv
// ----------------------------------------------------------------------------
// video_crop_measure
//   Consumes the mixer pixel stream, measures active frame geometry on every
//   frame and applies an optional, centred vertical crop by gating DE and
//   blanking colour outside the kept line window. All stream outputs are
//   registered on CE clocks and line up with CE_OUT (1 clock latency).
//
// Ports
//   CLK_VIDEO   video clock
//   RESET       asynchronous active-high reset
//   vin         incoming stream (slave): CE_PIXEL, VGA_*_IN
//   vout        outgoing stream (master): CE_OUT, VGA_* after crop
//   crop_en     enable vertical crop
//   crop_size   lines to keep, 0 = no crop
//   crop_off    signed offset of the kept window from centre (-16..+15)
//   hsize       active pixels of the last line of the last complete frame
//   vsize       active lines of the last complete frame
//   size_valid  a complete frame has been measured
//   frame_tgl   toggles whenever hsize/vsize are latched
// ----------------------------------------------------------------------------
module video_crop_measure #(
  parameter int WBITS = 12,
  parameter int HBITS = 12
) (
  input  logic                 CLK_VIDEO,
  input  logic                 RESET,
  video_crop_measure_if.slave  vin,
  video_crop_measure_if.master vout,
  input  logic                 crop_en,
  input  logic [HBITS-1:0]     crop_size,
  input  logic [4:0]           crop_off,
  output logic [WBITS-1:0]     hsize,
  output logic [HBITS-1:0]     vsize,
  output logic                 size_valid,
  output logic                 frame_tgl
);

  // previous-sample history for edge detection
  logic             prev_de_r;
  logic             prev_vs_r;
  // a VS rise has been seen since reset, so the current frame is complete
  logic             synced_r;
  logic [WBITS-1:0] hcnt_r;
  logic [WBITS-1:0] line_w_r;
  logic [HBITS-1:0] vcnt_r;
  // crop controls frozen at the start of the frame
  logic             crop_en_r;
  logic [HBITS-1:0] crop_size_r;
  logic [4:0]       crop_off_r;
  // measurement results
  logic [WBITS-1:0] hsize_r;
  logic [HBITS-1:0] vsize_r;
  logic             size_valid_r;
  logic             frame_tgl_r;
  // registered stream outputs
  logic             ce_out_r;
  logic [7:0]       r_out_r;
  logic [7:0]       g_out_r;
  logic [7:0]       b_out_r;
  logic             hs_out_r;
  logic             vs_out_r;
  logic             de_out_r;

  logic             de_fall_s;
  logic             vs_rise_s;
  logic [WBITS-1:0] hcnt_inc_s;
  logic [HBITS-1:0] vcnt_inc_s;
  logic [HBITS-1:0] vcnt_line_s;
  logic [WBITS-1:0] width_s;

  logic [HBITS-1:0] span_s;
  logic [HBITS+1:0] off_ext_s;
  logic [HBITS+1:0] start_raw_s;
  logic [HBITS-1:0] start_s;
  logic [HBITS:0]   end_s;
  logic             win_s;
  logic             keep_s;
  logic             de_keep_s;
  logic             pass_rgb_s;

  // Edge detection and saturating counter increments
  always_comb begin
    de_fall_s = prev_de_r & ~vin.de;
    vs_rise_s = vin.vs & ~prev_vs_r;

    if (hcnt_r == {WBITS{1'b1}}) begin
      hcnt_inc_s = hcnt_r;
    end else begin
      hcnt_inc_s = hcnt_r + {{(WBITS-1){1'b0}}, 1'b1};
    end

    if (vcnt_r == {HBITS{1'b1}}) begin
      vcnt_inc_s = vcnt_r;
    end else begin
      vcnt_inc_s = vcnt_r + {{(HBITS-1){1'b0}}, 1'b1};
    end

    // When a line ends on the same CE as VS rises, the frame latch must see
    // that line already counted and its width already captured.
    if (de_fall_s) begin
      vcnt_line_s = vcnt_inc_s;
      width_s     = hcnt_r;
    end else begin
      vcnt_line_s = vcnt_r;
      width_s     = line_w_r;
    end
  end

  // Crop window from the previous frame's size and the frozen crop controls
  always_comb begin
    span_s    = vsize_r - crop_size_r;
    off_ext_s = {{(HBITS-3){crop_off_r[4]}}, crop_off_r};
    // base < 2^(HBITS-1) and |offset| <= 16, so the MSB of this two's
    // complement sum is a reliable "negative" flag.
    start_raw_s = {3'b000, span_s[HBITS-1:1]} + off_ext_s;

    if (start_raw_s[HBITS+1]) begin
      start_s = {HBITS{1'b0}};
    end else if (start_raw_s > {2'b00, span_s}) begin
      start_s = span_s;
    end else begin
      start_s = start_raw_s[HBITS-1:0];
    end

    win_s = crop_en_r & (crop_size_r != {HBITS{1'b0}}) & size_valid_r &
            (crop_size_r < vsize_r);

    end_s      = {1'b0, start_s} + {1'b0, crop_size_r};
    keep_s     = (vcnt_r >= start_s) & ({1'b0, vcnt_r} < end_s);
    de_keep_s  = vin.de & (~win_s | keep_s);
    pass_rgb_s = de_keep_s | ~win_s;
  end

  // Registered stream outputs: CE copy every clock, data on CE clocks
  always_ff @(posedge CLK_VIDEO or posedge RESET) begin
    if (RESET) begin
      ce_out_r <= 1'b0;
      r_out_r  <= 8'h00;
      g_out_r  <= 8'h00;
      b_out_r  <= 8'h00;
      hs_out_r <= 1'b0;
      vs_out_r <= 1'b0;
      de_out_r <= 1'b0;
    end else begin
      ce_out_r <= vin.ce;
      if (vin.ce) begin
        hs_out_r <= vin.hs;
        vs_out_r <= vin.vs;
        de_out_r <= de_keep_s;
        r_out_r  <= pass_rgb_s ? vin.r : 8'h00;
        g_out_r  <= pass_rgb_s ? vin.g : 8'h00;
        b_out_r  <= pass_rgb_s ? vin.b : 8'h00;
      end
    end
  end

  // Geometry measurement, frame latch and crop control sampling
  always_ff @(posedge CLK_VIDEO or posedge RESET) begin
    if (RESET) begin
      prev_de_r    <= 1'b0;
      prev_vs_r    <= 1'b0;
      synced_r     <= 1'b0;
      hcnt_r       <= {WBITS{1'b0}};
      line_w_r     <= {WBITS{1'b0}};
      vcnt_r       <= {HBITS{1'b0}};
      crop_en_r    <= 1'b0;
      crop_size_r  <= {HBITS{1'b0}};
      crop_off_r   <= 5'b00000;
      hsize_r      <= {WBITS{1'b0}};
      vsize_r      <= {HBITS{1'b0}};
      size_valid_r <= 1'b0;
      frame_tgl_r  <= 1'b0;
    end else if (vin.ce) begin
      prev_de_r <= vin.de;
      prev_vs_r <= vin.vs;

      if (de_fall_s) begin
        line_w_r <= hcnt_r;
        hcnt_r   <= {WBITS{1'b0}};
      end else if (vin.de) begin
        hcnt_r <= hcnt_inc_s;
      end

      if (vs_rise_s) begin
        vcnt_r      <= {HBITS{1'b0}};
        synced_r    <= 1'b1;
        crop_en_r   <= crop_en;
        crop_size_r <= crop_size;
        crop_off_r  <= crop_off;
        // The first VS after reset only opens a frame; the lines before it
        // belong to a partial frame and are never reported.
        if (synced_r && (vcnt_line_s != {HBITS{1'b0}})) begin
          vsize_r      <= vcnt_line_s;
          hsize_r      <= width_s;
          size_valid_r <= 1'b1;
          frame_tgl_r  <= ~frame_tgl_r;
        end
      end else if (de_fall_s) begin
        vcnt_r <= vcnt_inc_s;
      end
    end
  end

  assign vout.ce    = ce_out_r;
  assign vout.r     = r_out_r;
  assign vout.g     = g_out_r;
  assign vout.b     = b_out_r;
  assign vout.hs    = hs_out_r;
  assign vout.vs    = vs_out_r;
  assign vout.de    = de_out_r;
  assign hsize      = hsize_r;
  assign vsize      = vsize_r;
  assign size_valid = size_valid_r;
  assign frame_tgl  = frame_tgl_r;

endmodule

// File: tb/tb_video_crop_measure.sv
// ----------------------------------------------------------------------------
// tb_video_crop_measure
//   Drives whole frames (240 active lines, narrow random line widths, random
//   CE gaps and colours) into video_crop_measure. A frame-level reference
//   model predicts the measured size and the kept line window; every output
//   pixel is compared against it and per-frame observations are checked.
// ----------------------------------------------------------------------------
module tb_video_crop_measure;
  localparam int WBITS = 12;
  localparam int HBITS = 12;
  localparam int NL    = 240;

  logic             CLK_VIDEO = 1'b0;
  logic             RESET     = 1'b1;
  logic             crop_en   = 1'b0;
  logic [HBITS-1:0] crop_size = '0;
  logic [4:0]       crop_off  = '0;
  logic [WBITS-1:0] hsize;
  logic [HBITS-1:0] vsize;
  logic             size_valid;
  logic             frame_tgl;

  video_crop_measure_if vin_if();
  video_crop_measure_if vout_if();

  video_crop_measure #(.WBITS(WBITS), .HBITS(HBITS)) dut (
    .CLK_VIDEO  (CLK_VIDEO),
    .RESET      (RESET),
    .vin        (vin_if),
    .vout       (vout_if),
    .crop_en    (crop_en),
    .crop_size  (crop_size),
    .crop_off   (crop_off),
    .hsize      (hsize),
    .vsize      (vsize),
    .size_valid (size_valid),
    .frame_tgl  (frame_tgl)
  );

  always #5 CLK_VIDEO = ~CLK_VIDEO;

  int errors = 0;
  int checks = 0;

  // frame-level reference model
  int  m_vsize, m_hsize, prev_lines, prev_lastw;
  bit  m_valid, m_tgl, m_synced;
  bit  w_on;
  int  w_start, w_len;
  // expected registered outputs (held between CE clocks)
  logic       e_de, e_hs, e_vs;
  logic [7:0] e_r, e_g, e_b;
  // per-frame observations
  int cur_line, pix_bad, obs_first, obs_last, obs_lines, obs_px;
  logic [53:0] rst_snap;

  // one pixel with 0..1 idle clocks before it; outputs compared to the model
  task automatic pix(input logic de, input logic hs, input logic vs);
    logic [7:0] r, g, b;
    logic ede, pass;
    int gaps;
    r = 8'($urandom_range(1, 255));
    g = 8'($urandom_range(1, 255));
    b = 8'($urandom_range(1, 255));
    gaps = $urandom_range(0, 1);
    for (int k = 0; k < gaps; k++) begin
      vin_if.ce = 1'b0;
      @(posedge CLK_VIDEO); #1;
      if (vout_if.ce !== 1'b0 || vout_if.de !== e_de || vout_if.hs !== e_hs ||
          vout_if.vs !== e_vs || vout_if.r !== e_r || vout_if.g !== e_g ||
          vout_if.b !== e_b) pix_bad++;
    end
    vin_if.ce = 1'b1; vin_if.de = de; vin_if.hs = hs; vin_if.vs = vs;
    vin_if.r = r; vin_if.g = g; vin_if.b = b;
    @(posedge CLK_VIDEO); #1;
    ede  = de && (!w_on || (cur_line >= w_start && cur_line < w_start + w_len));
    pass = ede || !w_on;
    e_de = ede; e_hs = hs; e_vs = vs;
    e_r = pass ? r : 8'h00;
    e_g = pass ? g : 8'h00;
    e_b = pass ? b : 8'h00;
    if (vout_if.ce !== 1'b1 || vout_if.de !== e_de || vout_if.hs !== e_hs ||
        vout_if.vs !== e_vs || vout_if.r !== e_r || vout_if.g !== e_g ||
        vout_if.b !== e_b) pix_bad++;
    if (vout_if.de === 1'b1) begin
      if (obs_first < 0) obs_first = cur_line;
      if (cur_line != obs_last) obs_lines++;
      obs_last = cur_line;
      obs_px++;
    end
  endtask

  // one frame: VS rise, nl active lines, optional reset before line rst_line
  task automatic send_frame(input int w, input int lastw, input int nl,
                            input bit tight, input int rst_line, input bit mid_change);
    int off, span, wl;
    pix_bad = 0; obs_first = -1; obs_last = -1; obs_lines = 0; obs_px = 0;
    cur_line = -1;
    pix(1'b0, 1'b0, 1'b1);
    // frame boundary in the model: report previous frame, freeze crop
    if (m_synced && prev_lines > 0) begin
      m_vsize = prev_lines; m_hsize = prev_lastw; m_valid = 1'b1; m_tgl = ~m_tgl;
    end
    m_synced = 1'b1; prev_lines = 0;
    w_on = crop_en && crop_size != 0 && m_valid && int'(crop_size) < m_vsize;
    if (w_on) begin
      off = crop_off[4] ? int'(crop_off) - 32 : int'(crop_off);
      span = m_vsize - int'(crop_size);
      w_start = span / 2 + off;
      if (w_start < 0) w_start = 0;
      if (w_start > span) w_start = span;
      w_len = int'(crop_size);
    end
    pix(1'b0, 1'b0, 1'b1); pix(1'b0, 1'b0, 1'b1);
    pix(1'b0, 1'b0, 1'b0); pix(1'b0, 1'b0, 1'b0);
    for (int l = 0; l < nl; l++) begin
      if (l == rst_line) begin
        #2; RESET = 1'b1; #1;
        rst_snap = {vout_if.ce, vout_if.de, vout_if.hs, vout_if.vs, vout_if.r,
                    vout_if.g, vout_if.b, hsize, vsize, size_valid, frame_tgl};
        m_vsize = 0; m_hsize = 0; m_valid = 1'b0; m_tgl = 1'b0; m_synced = 1'b0;
        prev_lines = 0; w_on = 1'b0;
        e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_r = 8'h00; e_g = 8'h00; e_b = 8'h00;
        vin_if.ce = 1'b0;
        @(negedge CLK_VIDEO); @(negedge CLK_VIDEO); RESET = 1'b0;
        @(posedge CLK_VIDEO); #1;
      end
      if (mid_change && l == nl / 2) begin
        crop_en   = 1'($urandom_range(0, 1));
        crop_size = HBITS'($urandom_range(0, 300));
        crop_off  = 5'($urandom_range(0, 31));
      end
      cur_line = l;
      wl = (l == nl - 1) ? lastw : w;
      repeat (wl) pix(1'b1, 1'b0, 1'b0);
      if (!(tight && l == nl - 1)) begin
        pix(1'b0, 1'b0, 1'b0); pix(1'b0, 1'b1, 1'b0);
      end
      prev_lines++; prev_lastw = wl;
    end
    if (!tight) begin
      pix(1'b0, 1'b0, 1'b0); pix(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(posedge CLK_VIDEO); #1;
    checks++; if (vout_if.ce !== 1'b0 || vout_if.de !== 1'b0) begin errors++; $display("FAIL reset_ce_de: got %b%b expected 00", vout_if.ce, vout_if.de); end
    checks++; if (vout_if.hs !== 1'b0 || vout_if.vs !== 1'b0) begin errors++; $display("FAIL reset_syncs: got %b%b expected 00", vout_if.hs, vout_if.vs); end
    checks++; if ({vout_if.r, vout_if.g, vout_if.b} !== 24'h0) begin errors++; $display("FAIL reset_rgb: got %h expected 0", {vout_if.r, vout_if.g, vout_if.b}); end
    checks++; if (hsize !== '0 || vsize !== '0) begin errors++; $display("FAIL reset_size: got %0d x %0d expected 0 x 0", hsize, vsize); end
    checks++; if (size_valid !== 1'b0 || frame_tgl !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b%b expected 00", size_valid, frame_tgl); end
    @(negedge CLK_VIDEO); RESET = 1'b0;
    @(posedge CLK_VIDEO); #1;
    checks++; if (size_valid !== 1'b0 || vout_if.ce !== 1'b0) begin errors++; $display("FAIL reset_release: got valid=%b ce=%b expected 0 0", size_valid, vout_if.ce); end
  endtask

  task automatic test_measure();
    int w0, l0, w1, l1, w2, l2;
    crop_en = 1'b0;
    w0 = $urandom_range(3, 5); l0 = $urandom_range(2, 8);
    w1 = $urandom_range(3, 5); l1 = $urandom_range(2, 8);
    w2 = $urandom_range(3, 5); l2 = $urandom_range(2, 8);
    send_frame(w0, l0, NL, 1'b0, -1, 1'b0);
    checks++; if (size_valid !== 1'b0) begin errors++; $display("FAIL measure_first_valid: got %b expected 0", size_valid); end
    checks++; if (pix_bad != 0) begin errors++; $display("FAIL measure_f0_stream: got %0d bad pixels expected 0", pix_bad); end
    send_frame(w1, l1, NL, 1'b0, -1, 1'b0);
    checks++; if (hsize !== WBITS'(l0)) begin errors++; $display("FAIL measure_hsize: got %0d expected %0d", hsize, l0); end
    checks++; if (vsize !== HBITS'(NL) || size_valid !== 1'b1) begin errors++; $display("FAIL measure_vsize: got %0d valid=%b expected %0d valid=1", vsize, size_valid, NL); end
    checks++; if (frame_tgl !== 1'b1) begin errors++; $display("FAIL measure_tgl1: got %b expected 1", frame_tgl); end
    checks++; if (pix_bad != 0) begin errors++; $display("FAIL measure_f1_stream: got %0d bad pixels expected 0", pix_bad); end
    checks++; if (obs_lines != NL || obs_first != 0 || obs_px != (NL - 1) * w1 + l1) begin errors++; $display("FAIL measure_de_pass: got lines=%0d first=%0d px=%0d expected %0d 0 %0d", obs_lines, obs_first, obs_px, NL, (NL - 1) * w1 + l1); end
    send_frame(w2, l2, NL, 1'b0, -1, 1'b0);
    checks++; if (frame_tgl !== 1'b0 || hsize !== WBITS'(l1)) begin errors++; $display("FAIL measure_tgl2: got tgl=%b hsize=%0d expected 0 %0d", frame_tgl, hsize, l1); end
  endtask

  task automatic test_crop_center();
    crop_en = 1'b1; crop_size = HBITS'(224); crop_off = 5'd0;
    send_frame(4, 5, NL, 1'b0, -1, 1'b0);
    checks++; if (obs_first != 8 || obs_last != 231) begin errors++; $display("FAIL crop_center_range: got %0d..%0d expected 8..231", obs_first, obs_last); end
    checks++; if (obs_lines != 224 || obs_px != 224 * 4) begin errors++; $display("FAIL crop_center_count: got lines=%0d px=%0d expected 224 %0d", obs_lines, obs_px, 224 * 4); end
    checks++; if (pix_bad != 0) begin errors++; $display("FAIL crop_center_stream: got %0d bad pixels expected 0", pix_bad); end
  endtask

  task automatic test_crop_clamp();
    crop_en = 1'b1; crop_size = HBITS'(224); crop_off = 5'b01111;
    send_frame(4, 6, NL, 1'b0, -1, 1'b0);
    checks++; if (obs_first != 16 || obs_last != 239 || obs_lines != 224) begin errors++; $display("FAIL crop_plus15: got %0d..%0d lines=%0d expected 16..239 224", obs_first, obs_last, obs_lines); end
    checks++; if (obs_px != 223 * 4 + 6 || pix_bad != 0) begin errors++; $display("FAIL crop_plus15_px: got px=%0d bad=%0d expected %0d 0", obs_px, pix_bad, 223 * 4 + 6); end
    crop_off = 5'b10000;
    send_frame(4, 6, NL, 1'b0, -1, 1'b0);
    checks++; if (obs_first != 0 || obs_last != 223 || obs_lines != 224) begin errors++; $display("FAIL crop_minus16: got %0d..%0d lines=%0d expected 0..223 224", obs_first, obs_last, obs_lines); end
    checks++; if (pix_bad != 0) begin errors++; $display("FAIL crop_minus16_stream: got %0d bad pixels expected 0", pix_bad); end
  endtask

  task automatic test_no_crop();
    int sizes [3] = '{240, 300, 0};
    crop_en = 1'b1; crop_off = 5'd0;
    foreach (sizes[i]) begin
      crop_size = HBITS'(sizes[i]);
      send_frame(3, 4, NL, 1'b0, -1, 1'b0);
      checks++; if (obs_lines != NL || obs_first != 0 || pix_bad != 0) begin errors++; $display("FAIL no_crop_%0d: got lines=%0d first=%0d bad=%0d expected %0d 0 0", sizes[i], obs_lines, obs_first, pix_bad, NL); end
    end
  endtask

  task automatic test_back_to_back();
    int bad_first;
    crop_en = 1'b0;
    send_frame(3, 7, NL, 1'b1, -1, 1'b0);
    bad_first = pix_bad;
    send_frame(4, 4, NL, 1'b0, -1, 1'b0);
    checks++; if (vsize !== HBITS'(NL)) begin errors++; $display("FAIL b2b_vsize: got %0d expected %0d", vsize, NL); end
    checks++; if (hsize !== WBITS'(7)) begin errors++; $display("FAIL b2b_hsize: got %0d expected 7", hsize); end
    checks++; if (bad_first != 0 || pix_bad != 0) begin errors++; $display("FAIL b2b_stream: got %0d/%0d bad pixels expected 0/0", bad_first, pix_bad); end
  endtask

  task automatic test_reset_midframe();
    crop_en = 1'b1; crop_size = HBITS'(200); crop_off = 5'd3;
    send_frame(4, 5, NL, 1'b0, 100, 1'b0);
    checks++; if (rst_snap !== '0) begin errors++; $display("FAIL midrst_outputs: got %h expected 0", rst_snap); end
    checks++; if (size_valid !== 1'b0 || vsize !== '0 || pix_bad != 0) begin errors++; $display("FAIL midrst_partial: got valid=%b vsize=%0d bad=%0d expected 0 0 0", size_valid, vsize, pix_bad); end
    send_frame(4, 6, NL, 1'b0, -1, 1'b0);
    checks++; if (size_valid !== 1'b0 || obs_lines != NL) begin errors++; $display("FAIL midrst_sync_frame: got valid=%b lines=%0d expected 0 %0d", size_valid, obs_lines, NL); end
    send_frame(5, 3, NL, 1'b0, -1, 1'b0);
    checks++; if (size_valid !== 1'b1 || vsize !== HBITS'(NL) || hsize !== WBITS'(6) || frame_tgl !== 1'b1) begin errors++; $display("FAIL midrst_first_full: got valid=%b %0dx%0d tgl=%b expected 1 6x%0d 1", size_valid, hsize, vsize, frame_tgl, NL); end
    checks++; if (obs_first != 23 || obs_lines != 200 || pix_bad != 0) begin errors++; $display("FAIL midrst_crop: got first=%0d lines=%0d bad=%0d expected 23 200 0", obs_first, obs_lines, pix_bad); end
  endtask

  task automatic test_random();
    int nl, exp_kept, lo, hi;
    for (int it = 0; it < 3; it++) begin
      crop_en   = 1'($urandom_range(0, 1));
      crop_size = ($urandom_range(0, 3) == 0) ? HBITS'(0) : HBITS'($urandom_range(100, 260));
      crop_off  = 5'($urandom_range(0, 31));
      nl = $urandom_range(230, 240);
      send_frame($urandom_range(3, 5), $urandom_range(2, 8), nl, 1'($urandom_range(0, 1)), -1, 1'b1);
      lo = (w_start < nl) ? w_start : nl;
      hi = (w_start + w_len < nl) ? w_start + w_len : nl;
      exp_kept = w_on ? hi - lo : nl;
      checks++; if (pix_bad != 0) begin errors++; $display("FAIL random_%0d_stream: got %0d bad pixels expected 0", it, pix_bad); end
      checks++; if (vsize !== HBITS'(m_vsize) || hsize !== WBITS'(m_hsize)) begin errors++; $display("FAIL random_%0d_size: got %0dx%0d expected %0dx%0d", it, hsize, vsize, m_hsize, m_vsize); end
      checks++; if (size_valid !== m_valid || frame_tgl !== m_tgl) begin errors++; $display("FAIL random_%0d_flags: got %b%b expected %b%b", it, size_valid, frame_tgl, m_valid, m_tgl); end
      checks++; if (obs_lines != exp_kept) begin errors++; $display("FAIL random_%0d_kept: got %0d lines expected %0d", it, obs_lines, exp_kept); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vin_if.ce = 1'b0; vin_if.de = 1'b0; vin_if.hs = 1'b0; vin_if.vs = 1'b0;
    vin_if.r = 8'h00; vin_if.g = 8'h00; vin_if.b = 8'h00;
    m_vsize = 0; m_hsize = 0; m_valid = 1'b0; m_tgl = 1'b0; m_synced = 1'b0;
    prev_lines = 0; prev_lastw = 0; w_on = 1'b0; w_start = 0; w_len = 0;
    e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_r = 8'h00; e_g = 8'h00; e_b = 8'h00;
    cur_line = -1; pix_bad = 0; obs_first = -1; obs_last = -1; obs_lines = 0; obs_px = 0;
    rst_snap = '1;

    test_reset();
    test_measure();
    test_crop_center();
    test_crop_clamp();
    test_no_crop();
    test_back_to_back();
    test_reset_midframe();
    test_random();

    vin_if.ce = 1'b0;
    repeat (4) @(posedge CLK_VIDEO);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
